brisc_mem_arbiter: RTL and testbench
====================================

Name: brisc_mem_arbiter

Overview:
Parametrised main-memory model with an N-port round-robin front end. It serves cache line-fill and write-back requests, in mem_req_t / mem_resp_t format, from NUM_PORTS requesters (I-cache, D-cache, future cores) with configurable request and response latency. It sits below the caches and replaces the single-port fixed-delay memory. One transaction is in flight at a time.

Parameters:
NUM_PORTS, 2, number of requesters (>=1)
LINE_WIDTH, CACHE_LINE_WIDTH (128), bits per line; must be a multiple of WORD_WIDTH
DEPTH_WORDS, MEM_DEPTH (8192), backing store size in 32-bit words
REQ_DELAY, MEM_REQ_DELAY (5), cycles from grant to array access (>=1)
RESP_DELAY, MEM_RESP_DELAY (5), cycles from array access to response (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
req_i  in  NUM_PORTS x mem_req_t  per-port request {valid, rw, addr, data}
resp_o  out  NUM_PORTS x mem_resp_t  per-port response {ready, addr, data}
grant_o  out  NUM_PORTS  one-hot owner of the in-flight transaction; 0 when idle
busy_o  out  1  high while not in IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=0; counter=0; grant_o=0; busy_o=0; all resp_o fields 0. Array contents are not reset.
- Line index = addr[OFFSET+LIDX-1 : OFFSET], where OFFSET=$clog2(LINE_WIDTH/8) and LIDX=$clog2(DEPTH_WORDS*32/LINE_WIDTH). Low offset bits and upper bits are ignored, so addresses wrap modulo the array size.
- Handshake:
  - A requester holds valid/rw/addr/data stable until its resp_o.ready pulse.
  - It drops valid in the following cycle or issues a new request.
  - ready is a single-cycle pulse.
- FSM:
  - IDLE: if any valid, pick the first valid port scanning rr_ptr, rr_ptr+1, ... (mod NUM_PORTS). Latch port id, rw, addr, data. Load counter=REQ_DELAY-1. Go to REQ_WAIT. Set grant_o one-hot from the next cycle.
  - REQ_WAIT: decrement the counter. At 0, perform the access (write: line <= data; read: latch line) and load counter=RESP_DELAY-1. Go to RESP_WAIT.
  - RESP_WAIT: decrement the counter. At 0, go to RESP.
  - RESP: resp_o[owner].ready=1, addr=latched addr, data=read line (reads) or echoed write data (writes). rr_ptr=owner+1 mod NUM_PORTS. Go to IDLE. grant_o cleared next cycle.
- Latency: valid first sampled in IDLE in cycle 0 -> ready in cycle REQ_DELAY+RESP_DELAY+1 (default 11). Next grant no earlier than the cycle after RESP.
- Non-owner resp_o fields are held at 0. Requests arriving while busy wait; there is no queueing beyond the held valid.
- A request withdrawn before grant is ignored. Withdrawal after grant is illegal; the transaction completes regardless.
- Reset mid-transaction aborts it: no ready is issued. A write whose access edge has already passed stays committed.
- NUM_PORTS=1 degenerates to a fixed-delay single-port memory.

Optional Feature:
BRISC_MEM_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest port index wins; rr_ptr is unused and held at 0.
- Undefined: round-robin as above. The default build is round-robin.

Decomposition:
- Add to brisc_pkg: NUM_MEM_PORTS, mem_arb_state_e {IDLE, REQ_WAIT, RESP_WAIT, RESP}, and the LIDX/OFFSET helper localparams.
- Reuse the existing mem_req_t and mem_resp_t.
- Sub-module rr_arbiter (NUM_PORTS, req vector, ptr -> one-hot grant + index). It is purely combinational and holds the fixed-priority ifdef.

Test Plan:
- Single read, port 0, addr 0x4000 after a write of line 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to the same address -> ready in cycle 11, data equals the line, addr=0x4000.
- Ports 0 and 1 valid simultaneously from reset -> port 0 served first and port 1 granted the cycle after port 0's ready; repeat -> order alternates 0,1,0,1.
- Write 0xA5..A5 to 0x4010, then read 0x4018 -> same line returned (offset ignored); read of 0x4010 + DEPTH_WORDS*4 aliases to the same line.
- rst_n pulled low during REQ_WAIT of a write to 0x5000 -> no ready, all outputs 0, the line at 0x5000 is unchanged; the first post-reset request is served normally.
- With BRISC_MEM_ARB_FIXED_PRIO_EN, port 0 re-requests continuously while port 1 waits -> port 1 is never granted until port 0 drops valid.
- REQ_DELAY=1, RESP_DELAY=1 -> ready in cycle 3; back-to-back requests complete every 4 cycles.

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared BRISC memory-system types: request/response formats, memory defaults
// and the line-geometry helpers used by the main-memory arbiter.
package brisc_pkg;

    localparam int unsigned ADDR_WIDTH       = 32;
    localparam int unsigned WORD_WIDTH       = 32;
    localparam int unsigned CACHE_LINE_WIDTH = 128;
    localparam int unsigned MEM_DEPTH        = 8192;
    localparam int unsigned MEM_REQ_DELAY    = 5;
    localparam int unsigned MEM_RESP_DELAY   = 5;
    localparam int unsigned NUM_MEM_PORTS    = 2;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    typedef struct packed {
        logic                        valid;
        logic                        rw;
        logic [ADDR_WIDTH-1:0]       addr;
        logic [CACHE_LINE_WIDTH-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic                        ready;
        logic [ADDR_WIDTH-1:0]       addr;
        logic [CACHE_LINE_WIDTH-1:0] data;
    } mem_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ_WAIT,
        RESP_WAIT,
        RESP
    } mem_arb_state_e;

    function automatic int unsigned line_offset_bits(input int unsigned line_width);
        return $clog2(line_width / 8);
    endfunction

    function automatic int unsigned line_index_bits(input int unsigned depth_words,
                                                    input int unsigned line_width);
        return $clog2(depth_words * WORD_WIDTH / line_width);
    endfunction

    localparam int unsigned MEM_OFFSET = line_offset_bits(CACHE_LINE_WIDTH);
    localparam int unsigned MEM_LIDX   = line_index_bits(MEM_DEPTH, CACHE_LINE_WIDTH);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: one-hot grant plus index of the winner.
// Round-robin from ptr by default; BRISC_MEM_ARB_FIXED_PRIO_EN selects lowest-index-wins.
module rr_arbiter #(
    parameter  int unsigned NUM_PORTS = 2,
    localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PTR_W-1:0]     idx
);

    logic found;

`ifdef BRISC_MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
            end
        end
    end
`else
    // Scan distance k from ptr; compare against every port to avoid a variable index.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                if (!found && req[j] && (j == (32'(ptr) + k) % NUM_PORTS)) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    idx      = PTR_W'(j);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/brisc_mem_arbiter.sv
// N-port main-memory model: arbitrated front end, one transaction in flight,
// fixed request/response latency. Macro BRISC_MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module brisc_mem_arbiter
    import brisc_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = NUM_MEM_PORTS,
    parameter int unsigned LINE_WIDTH  = CACHE_LINE_WIDTH,
    parameter int unsigned DEPTH_WORDS = MEM_DEPTH,
    parameter int unsigned REQ_DELAY   = MEM_REQ_DELAY,
    parameter int unsigned RESP_DELAY  = MEM_RESP_DELAY
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  mem_req_t  [NUM_PORTS-1:0] req_i,
    output mem_resp_t [NUM_PORTS-1:0] resp_o,
    output logic      [NUM_PORTS-1:0] grant_o,
    output logic                      busy_o
);

    localparam int unsigned OFFSET    = line_offset_bits(LINE_WIDTH);
    localparam int unsigned LIDX      = line_index_bits(DEPTH_WORDS, LINE_WIDTH);
    localparam int unsigned NUM_LINES = 1 << LIDX;
    localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned MAX_DELAY = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
    localparam int unsigned CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    mem_arb_state_e         state;
    logic [CNT_W-1:0]       cnt;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       owner;
    logic                   lat_rw;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [LINE_WIDTH-1:0]  lat_data;
    logic [LINE_WIDTH-1:0]  rd_line;
    logic [LINE_WIDTH-1:0]  resp_line;
    logic [LIDX-1:0]        line_idx;
    logic                   access_en;

    logic [NUM_PORTS-1:0]   req_valid;
    logic [NUM_PORTS-1:0]   arb_grant;
    logic [PTR_W-1:0]       arb_idx;
    logic                   sel_rw;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LINE_WIDTH-1:0]  sel_data;

    logic [LINE_WIDTH-1:0]  mem_array [NUM_LINES];

    always_comb begin
        req_valid = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            req_valid[j] = req_i[j].valid;
        end
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        sel_rw   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (arb_grant[j]) begin
                sel_rw   = req_i[j].rw;
                sel_addr = req_i[j].addr;
                sel_data = req_i[j].data[LINE_WIDTH-1:0];
            end
        end
    end

    assign line_idx  = lat_addr[OFFSET+LIDX-1:OFFSET];
    assign access_en = (state == REQ_WAIT) && (cnt == '0);
    assign resp_line = lat_rw ? lat_data : rd_line;
    assign busy_o    = (state != IDLE);

    // Array is outside the reset domain: an access edge already taken stays committed.
    always_ff @(posedge clk) begin
        if (access_en) begin
            if (lat_rw) begin
                mem_array[line_idx] <= lat_data;
            end else begin
                rd_line <= mem_array[line_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
            lat_rw   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            grant_o  <= '0;
            resp_o   <= '0;
        end else begin
            resp_o <= '0;
            case (state)
                IDLE: begin
                    if (|arb_grant) begin
                        owner    <= arb_idx;
                        lat_rw   <= sel_rw;
                        lat_addr <= sel_addr;
                        lat_data <= sel_data;
                        cnt      <= CNT_W'(REQ_DELAY - 1);
                        grant_o  <= arb_grant;
                        state    <= REQ_WAIT;
                    end
                end
                REQ_WAIT: begin
                    if (cnt == '0) begin
                        cnt   <= CNT_W'(RESP_DELAY - 1);
                        state <= RESP_WAIT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP_WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                            if (PTR_W'(j) == owner) begin
                                resp_o[j].ready <= 1'b1;
                                resp_o[j].addr  <= lat_addr;
                                resp_o[j].data  <= CACHE_LINE_WIDTH'(resp_line);
                            end
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
`ifdef BRISC_MEM_ARB_FIXED_PRIO_EN
                    rr_ptr <= '0;
`else
                    rr_ptr <= (owner == PTR_W'(NUM_PORTS - 1)) ? '0 : owner + PTR_W'(1);
`endif
                    grant_o <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brisc_mem_arbiter.sv
// Self-checking bench for brisc_mem_arbiter: cycle-level reference model of the
// arbitration/latency rules plus a line-indexed memory image.
module tb_brisc_mem_arbiter;
    import brisc_pkg::*;

    localparam int NP     = 2;
    localparam int LAT    = MEM_REQ_DELAY + MEM_RESP_DELAY + 1;
    localparam int NLINES = MEM_DEPTH * 4 / 16;
    localparam int BUDGET = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    mem_req_t  [NP-1:0] req, req_f;
    mem_resp_t [NP-1:0] resp, resp_f;
    logic      [NP-1:0] grant, grant_f;
    logic               busy, busy_f;

    always #5 clk = ~clk;

    brisc_mem_arbiter #(.NUM_PORTS(NP)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .resp_o(resp), .grant_o(grant), .busy_o(busy)
    );

    brisc_mem_arbiter #(.NUM_PORTS(NP), .REQ_DELAY(1), .RESP_DELAY(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .req_i(req_f), .resp_o(resp_f), .grant_o(grant_f), .busy_o(busy_f)
    );

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
    } op_t;

    op_t          pq [NP][$];
    logic [127:0] model_mem [int];
    int           served [$];
    int           m_ptr;
    int           obs_lat;
    int           vectors;
    int           miscompares;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(input logic rw, input logic [31:0] a, input logic [127:0] d);
        op_t o;
        o.rw = rw; o.addr = a; o.data = d;
        return o;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) % 32'(NLINES));
    endfunction

    function automatic int pick();
`ifdef BRISC_MEM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NP; k++) if (pq[k].size() != 0) return k;
`else
        for (int k = 0; k < NP; k++) begin
            int p = (m_ptr + k) % NP;
            if (pq[p].size() != 0) return p;
        end
`endif
        return -1;
    endfunction

    task automatic drive_heads();
        for (int p = 0; p < NP; p++) begin
            if (pq[p].size() != 0) begin
                req[p].valid = 1'b1;
                req[p].rw    = pq[p][0].rw;
                req[p].addr  = pq[p][0].addr;
                req[p].data  = pq[p][0].data;
            end else begin
                req[p] = '0;
            end
        end
    endtask

    function automatic bit pending();
        for (int p = 0; p < NP; p++) if (pq[p].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Serve every queued op; each cycle compare grant/busy/resp against the model.
    task automatic run_batch();
        int cyc = 0;
        bit m_busy = 1'b0;
        int m_start = 0, m_ready = 0, m_owner = 0, w;
        logic [31:0] m_addr = '0;
        logic [127:0] m_data = '0;
        mem_resp_t [NP-1:0] exp_resp;
        logic [NP-1:0] exp_grant;
        @(posedge clk); #1;
        drive_heads();
        while ((pending() || m_busy) && cyc < BUDGET) begin
            @(negedge clk);
            if (!m_busy) begin
                w = pick();
                if (w >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = w;
                    m_start = cyc;
                    m_ready = cyc + LAT;
                    m_addr  = pq[w][0].addr;
                    obs_lat = -1;
                    if (pq[w][0].rw == MEM_WR) begin
                        model_mem[line_of(m_addr)] = pq[w][0].data;
                        m_data = pq[w][0].data;
                    end else begin
                        m_data = model_mem.exists(line_of(m_addr)) ? model_mem[line_of(m_addr)] : '0;
                    end
                end
            end
            exp_grant = '0;
            exp_resp  = '0;
            if (m_busy && cyc > m_start) exp_grant[m_owner] = 1'b1;
            if (m_busy && cyc == m_ready) begin
                exp_resp[m_owner].ready = 1'b1;
                exp_resp[m_owner].addr  = m_addr;
                exp_resp[m_owner].data  = m_data;
            end
            if (m_busy && resp[m_owner].ready === 1'b1 && obs_lat < 0) obs_lat = cyc - m_start;
            check("grant", 512'(grant), 512'(exp_grant));
            check("busy", 512'(busy), 512'(m_busy && cyc > m_start));
            check("resp", 512'(resp), 512'(exp_resp));
            if (m_busy && cyc == m_ready) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % NP;
                served.push_back(m_owner);
                void'(pq[m_owner].pop_front());
            end
            @(posedge clk); #1;
            drive_heads();
            cyc++;
        end
        vectors++;
        assert (cyc < BUDGET) else begin
            miscompares++;
            $error("FAIL batch_timeout: observed %0d cycles, expected < %0d", cyc, BUDGET);
        end
        for (int p = 0; p < NP; p++) pq[p].delete();
        drive_heads();
        @(negedge clk);
        check("idle_grant", 512'(grant), 512'(0));
        check("idle_busy", 512'(busy), 512'(0));
        check("idle_resp", 512'(resp), 512'(0));
    endtask

    initial begin
        int order_exp [4];
        int prio_exp [5];
        int cyc, got, n;
        logic [127:0] fd, v5000;
        int lines [8];
        logic [31:0] a;

        vectors = 0; miscompares = 0; m_ptr = 0; obs_lat = -1;
        req = '0; req_f = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant", 512'(grant), 512'(0));
        check("reset_busy", 512'(busy), 512'(0));
        check("reset_resp", 512'(resp), 512'(0));
        check("reset_fast_resp", 512'(resp_f), 512'(0));
        @(negedge clk) rst_n = 1'b1;

        // Both ports contend from reset: served order must alternate.
        pq[0].push_back(mk(MEM_WR, 32'h1000, 128'h11));
        pq[0].push_back(mk(MEM_WR, 32'h1010, 128'h22));
        pq[1].push_back(mk(MEM_WR, 32'h2000, 128'h33));
        pq[1].push_back(mk(MEM_WR, 32'h2010, 128'h44));
        served.delete();
        run_batch();
        order_exp = '{0, 1, 0, 1};
        check("rr_count", 512'(served.size()), 512'(4));
        for (int i = 0; i < 4; i++) check("rr_order", 512'(served[i]), 512'(order_exp[i]));

        // Write then read the same line.
        pq[0].push_back(mk(MEM_WR, 32'h4000, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677));
        pq[0].push_back(mk(MEM_RD, 32'h4000, '0));
        run_batch();
        check("read_latency", 512'(obs_lat), 512'(LAT));

        // Offset bits and upper bits are ignored.
        pq[0].push_back(mk(MEM_WR, 32'h4010, {16{8'hA5}}));
        pq[0].push_back(mk(MEM_RD, 32'h4018, '0));
        pq[0].push_back(mk(MEM_RD, 32'h4010 + MEM_DEPTH * 4, '0));
        run_batch();

        // Reset during REQ_WAIT of a write: aborted, line untouched.
        v5000 = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
        pq[1].push_back(mk(MEM_WR, 32'h5000, v5000));
        run_batch();
        @(posedge clk); #1;
        req[0].valid = 1'b1; req[0].rw = MEM_WR; req[0].addr = 32'h5000;
        req[0].data = {4{32'hDEAD_BEEF}};
        repeat (3) @(negedge clk);
        check("abort_busy_before", 512'(busy), 512'(1));
        #1 rst_n = 1'b0;
        #1;
        check("abort_grant", 512'(grant), 512'(0));
        check("abort_busy", 512'(busy), 512'(0));
        check("abort_resp", 512'(resp), 512'(0));
        @(posedge clk); #1 req = '0;
        @(negedge clk) rst_n = 1'b1;
        m_ptr = 0;
        repeat (14) begin
            @(negedge clk);
            check("abort_no_ready", 512'(resp), 512'(0));
        end
        pq[1].push_back(mk(MEM_RD, 32'h4000, '0));
        pq[0].push_back(mk(MEM_RD, 32'h5000, '0));
        served.delete();
        run_batch();
        check("post_reset_first", 512'(served[0]), 512'(0));

        // Port 0 keeps re-requesting while port 1 waits.
        for (int i = 0; i < 4; i++) pq[0].push_back(mk(MEM_WR, 32'h6000 + 32'(i * 16), 128'(i + 100)));
        pq[1].push_back(mk(MEM_WR, 32'h7000, 128'h77));
        served.delete();
        run_batch();
`ifdef BRISC_MEM_ARB_FIXED_PRIO_EN
        prio_exp = '{0, 0, 0, 0, 1};
`else
        prio_exp = '{0, 1, 0, 0, 0};
`endif
        for (int i = 0; i < 5; i++) check("prio_order", 512'(served[i]), 512'(prio_exp[i]));

        // Random traffic over a set of lines, with random offset and alias bits.
        for (int i = 0; i < 8; i++) begin
            lines[i] = int'($urandom_range(NLINES - 1));
            pq[i % NP].push_back(mk(MEM_WR, 32'(lines[i]) << 4, {$urandom, $urandom, $urandom, $urandom}));
        end
        run_batch();
        for (int i = 0; i < 16; i++) begin
            a = ($urandom & 32'hFFFF_800F) | (32'(lines[$urandom_range(7)]) << 4);
            pq[$urandom_range(NP - 1)].push_back(mk(1'($urandom_range(1)), a,
                {$urandom, $urandom, $urandom, $urandom}));
        end
        run_batch();

        // Minimum latency instance: ready in cycle 3, back-to-back every 4 cycles.
        fd = 128'hFEED_0000_BEEF_1111_C0DE_2222_F00D_3333;
        @(posedge clk); #1;
        req_f[0].valid = 1'b1; req_f[0].rw = MEM_WR; req_f[0].addr = 32'h100; req_f[0].data = fd;
        cyc = 0; got = -1;
        while (cyc < 20 && got < 0) begin
            @(negedge clk);
            if (resp_f[0].ready === 1'b1) got = cyc;
            cyc++;
        end
        check("fast_wr_latency", 512'(got), 512'(3));
        @(posedge clk); #1;
        req_f[0].rw = MEM_RD; req_f[0].data = '0;
        cyc = 0; n = 0;
        while (cyc < 40 && n < 3) begin
            @(negedge clk);
            if (resp_f[0].ready === 1'b1) begin
                check("fast_b2b_cycle", 512'(cyc), 512'(3 + 4 * n));
                check("fast_rd_data", 512'(resp_f[0].data), 512'(fd));
                check("fast_rd_addr", 512'(resp_f[0].addr), 512'(32'h100));
                n++;
            end
            cyc++;
        end
        check("fast_b2b_count", 512'(n), 512'(3));
        @(posedge clk); #1 req_f = '0;
        repeat (6) @(negedge clk);
        check("fast_idle_busy", 512'(busy_f), 512'(0));
        check("fast_idle_grant", 512'(grant_f), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
